// File: rtl/comp_pkg.sv
// Shared constants for the serial magnitude comparator: FSM state codes and flag reset values.
// No logic here; the flag reset values also seed the combinational cascade comparator inputs.
package comp_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic LGN_RST = 1'b0;
    localparam logic EQ_RST  = 1'b1;

endpackage

// File: rtl/comp_serial_core.sv
// Bit-serial compare core: resolves gt/eq from MSB-first bit pairs; flags freeze on first difference.
// Latency: lgn/e already include the bit presented this cycle; the flags register it on the edge.
// Backpressure: none; bits are consumed whenever bit_valid is high.
module comp_serial_core
    import comp_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic bit_valid,
    input  logic a,
    input  logic b,
    output logic lgn,
    output logic e
);

    logic gt_q;
    logic eq_q;
    logic diff;

    // Outputs are the flags with the current bit folded in, so the controller can
    // capture the final result on the same edge that consumes the last bit.
    assign diff = bit_valid && eq_q && (a != b);
    assign lgn  = diff ? (a & ~b) : gt_q;
    assign e    = diff ? 1'b0     : eq_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            gt_q <= LGN_RST;
            eq_q <= EQ_RST;
        end else begin
            gt_q <= lgn;
            eq_q <= e;
        end
    end

endmodule

// File: rtl/comp_seq_ctrl.sv
// Sequencer feeding two parallel operands MSB-first into the serial compare core.
// Latency: BIT_LEN cycles from start to done (or up to the first differing bit with EARLY_EXIT=1).
// Backpressure: start is only accepted in IDLE/DONE; a start during SHIFT is dropped, not queued.
module comp_seq_ctrl
    import comp_pkg::*;
#(
    parameter int BIT_LEN    = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BIT_LEN-1:0] a_in,
    input  logic [BIT_LEN-1:0] b_in,
    output logic               busy,
    output logic               done,
    output logic               lgn_out,
    output logic               e_out
);

    localparam int CW = (BIT_LEN > 1) ? $clog2(BIT_LEN) : 1;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [BIT_LEN-1:0] a_sh;
    logic [BIT_LEN-1:0] b_sh;
    logic               accept;
    logic               bit_valid;
    logic               finish;
    logic               core_lgn;
    logic               core_e;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign bit_valid = (state == SHIFT);
    // core_e drops only on the first differing bit, which is exactly the early-exit point.
    assign finish    = bit_valid && ((cnt == '0) || ((EARLY_EXIT != 0) && !core_e));
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);

    comp_serial_core u_core (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .bit_valid (bit_valid),
        .a         (a_sh[BIT_LEN-1]),
        .b         (b_sh[BIT_LEN-1]),
        .lgn       (core_lgn),
        .e         (core_e)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            lgn_out <= LGN_RST;
            e_out   <= EQ_RST;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state <= SHIFT;
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        cnt   <= CW'(BIT_LEN - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh << 1;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                    if (finish) begin
                        state   <= DONE;
                        lgn_out <= core_lgn;
                        e_out   <= core_e;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
